// File: rtl/mem_arbiter_pkg.sv
//============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared bus widths, the arbiter state encoding and the default
//            data-streak limit used by the instruction/data memory arbiter.
// Ports    : none (package)
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

package mem_arbiter_pkg;

    localparam int ADDR_WIDTH              = `RISCV_ADDR_WIDTH;
    localparam int WORD_WIDTH              = `RISCV_WORD_WIDTH;
    localparam int DEFAULT_MAX_DATA_STREAK = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
//============================================================================
// Module   : mem_arbiter_if
// Purpose  : Bundles the instruction-fetch port, the load/store port and the
//            shared memory bus seen by the arbiter.
// Modports : slave  - arbiter view (requests in, grants/memory bus out)
//            master - environment view (requesters and memory model)
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    // Instruction fetch port
    logic                  instr_valid_i;
    logic                  instr_ready_o;
    logic [ADDR_WIDTH-1:0] instr_addr_i;
    logic [WORD_WIDTH-1:0] instr_rdata_o;

    // Load/store port
    logic                  data_valid_i;
    logic                  data_ready_o;
    logic [ADDR_WIDTH-1:0] data_addr_i;
    logic [WORD_WIDTH-1:0] data_wdata_i;
    logic [3:0]            data_we_i;
    logic [WORD_WIDTH-1:0] data_rdata_o;

    // Shared memory bus
    logic                  mem_valid_o;
    logic                  mem_ready_i;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [WORD_WIDTH-1:0] mem_wdata_o;
    logic [3:0]            mem_we_o;
    logic [WORD_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  instr_valid_i, instr_addr_i,
        input  data_valid_i, data_addr_i, data_wdata_i, data_we_i,
        input  mem_ready_i, mem_rdata_i,
        output instr_ready_o, instr_rdata_o,
        output data_ready_o, data_rdata_o,
        output mem_valid_o, mem_addr_o, mem_wdata_o, mem_we_o
    );

    modport master (
        output instr_valid_i, instr_addr_i,
        output data_valid_i, data_addr_i, data_wdata_i, data_we_i,
        output mem_ready_i, mem_rdata_i,
        input  instr_ready_o, instr_rdata_o,
        input  data_ready_o, data_rdata_o,
        input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_we_o
    );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
//============================================================================
// Module   : mem_arbiter
// Purpose  : Two-requester arbiter sharing one memory port between the
//            instruction fetch unit and the load/store unit. Data requests
//            win by default; after MAX_DATA_STREAK consecutive data grants
//            taken while a fetch waits, the fetch is served next.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - mem_arbiter_if.slave (requester ports + memory bus)
//            busy_o - a grant is currently active
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_DATA_STREAK = DEFAULT_MAX_DATA_STREAK
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    mem_arbiter_if.slave bus,
    output logic         busy_o
);

    localparam int                  c_streak_w   = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(MAX_DATA_STREAK);

    arb_state_e              r_state;
    arb_state_e              w_state_nxt;
    logic [c_streak_w-1:0]   r_streak;
    logic [c_streak_w-1:0]   w_streak_nxt;
    logic                    w_arbitrate;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_streak <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_streak <= w_streak_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_streak_nxt      = r_streak;
        w_arbitrate       = 1'b0;
        bus.mem_valid_o   = 1'b0;
        bus.mem_addr_o    = '0;
        bus.mem_wdata_o   = '0;
        bus.mem_we_o      = 4'b0000;
        bus.instr_ready_o = 1'b0;
        bus.data_ready_o  = 1'b0;
        bus.instr_rdata_o = bus.mem_rdata_i;
        bus.data_rdata_o  = bus.mem_rdata_i;
        busy_o            = (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                w_arbitrate = 1'b1;
            end
            ST_GNT_I: begin
                bus.mem_valid_o   = 1'b1;
                bus.mem_addr_o    = bus.instr_addr_i;
                bus.instr_ready_o = bus.mem_ready_i;
                w_arbitrate       = bus.mem_ready_i;
            end
            ST_GNT_D: begin
                bus.mem_valid_o  = 1'b1;
                bus.mem_addr_o   = bus.data_addr_i;
                bus.mem_wdata_o  = bus.data_wdata_i;
                bus.mem_we_o     = bus.data_we_i;
                bus.data_ready_o = bus.mem_ready_i;
                w_arbitrate      = bus.mem_ready_i;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Arbitration uses the live valids, so a requester still asserting
        // valid on its completing cycle competes for the next grant.
        if (w_arbitrate) begin
            if (bus.data_valid_i && !(bus.instr_valid_i && (r_streak == c_streak_max))) begin
                w_state_nxt = ST_GNT_D;
            end else if (bus.instr_valid_i) begin
                w_state_nxt = ST_GNT_I;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end

        // Streak only counts data grants that bypass a waiting fetch.
        if (!bus.instr_valid_i) begin
            w_streak_nxt = '0;
        end else if (w_arbitrate && (w_state_nxt == ST_GNT_I)) begin
            w_streak_nxt = '0;
        end else if (w_arbitrate && (w_state_nxt == ST_GNT_D) && (r_streak != c_streak_max)) begin
            w_streak_nxt = r_streak + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter: table of per-cycle vectors,
//            hand-written multi-cycle sequences and a randomized run compared
//            against a transaction-level reference model.
// Ports    : none
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int MAX_STREAK = 4;

    logic clk;
    logic rst_n;
    logic busy;

    int errors;
    int checks;

    mem_arbiter_if bus ();

    mem_arbiter #(
        .MAX_DATA_STREAK(MAX_STREAK)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .busy_o (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       iv;
        logic       dv;
        logic       rdy;
        logic       mv;
        logic       ir;
        logic       dr;
        logic       bsy;
        logic [3:0] we;
    } vec_t;

    vec_t vecs [0:14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.instr_valid_i = 1'b0;
        bus.instr_addr_i  = '0;
        bus.data_valid_i  = 1'b0;
        bus.data_addr_i   = '0;
        bus.data_wdata_i  = '0;
        bus.data_we_i     = 4'h0;
        bus.mem_ready_i   = 1'b0;
        bus.mem_rdata_i   = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Reference model state: current grant (0 none, 1 fetch, 2 data) and
    // number of data grants taken past a waiting fetch.
    int m_gnt;
    int m_streak;

    initial begin
        errors = 0;
        checks = 0;

        // Starvation pattern: 4 data grants, 1 fetch grant, repeated.
        vecs[0]  = {3'b001, 4'b0000, 4'h0};
        vecs[1]  = {3'b001, 4'b0000, 4'h0};
        vecs[2]  = {3'b111, 4'b0000, 4'h0};
        vecs[3]  = {3'b111, 4'b1011, 4'hA};
        vecs[4]  = {3'b111, 4'b1011, 4'hA};
        vecs[5]  = {3'b111, 4'b1011, 4'hA};
        vecs[6]  = {3'b111, 4'b1011, 4'hA};
        vecs[7]  = {3'b111, 4'b1101, 4'h0};
        vecs[8]  = {3'b111, 4'b1011, 4'hA};
        vecs[9]  = {3'b111, 4'b1011, 4'hA};
        vecs[10] = {3'b111, 4'b1011, 4'hA};
        vecs[11] = {3'b111, 4'b1011, 4'hA};
        vecs[12] = {3'b111, 4'b1101, 4'h0};
        vecs[13] = {3'b001, 4'b1011, 4'hA};
        vecs[14] = {3'b000, 4'b0000, 4'h0};

        clear_inputs();
        rst_n = 1'b0;
        #1;
        chk("reset mem_valid", bus.mem_valid_o, 0);
        chk("reset busy", busy, 0);
        chk("reset mem_addr", bus.mem_addr_o, 0);
        chk("reset mem_we", bus.mem_we_o, 0);
        chk("reset mem_wdata", bus.mem_wdata_o, 0);
        chk("reset ready", {bus.instr_ready_o, bus.data_ready_o}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        bus.instr_addr_i = 32'h0000_7000;
        bus.data_addr_i  = 32'h0000_6000;
        bus.data_wdata_i = 32'h1234_5678;
        bus.data_we_i    = 4'hA;
        for (int i = 0; i < 15; i++) begin
            bus.instr_valid_i = vecs[i].iv;
            bus.data_valid_i  = vecs[i].dv;
            bus.mem_ready_i   = vecs[i].rdy;
            settle();
            chk($sformatf("vec%0d mem_valid", i), bus.mem_valid_o, vecs[i].mv);
            chk($sformatf("vec%0d instr_ready", i), bus.instr_ready_o, vecs[i].ir);
            chk($sformatf("vec%0d data_ready", i), bus.data_ready_o, vecs[i].dr);
            chk($sformatf("vec%0d busy", i), busy, vecs[i].bsy);
            chk($sformatf("vec%0d mem_we", i), bus.mem_we_o, vecs[i].we);
            tick();
        end

        // ---------------- single fetch ----------------
        clear_inputs();
        bus.instr_valid_i = 1'b1;
        bus.instr_addr_i  = 32'h0000_0100;
        settle();
        chk("fetch idle mem_valid", bus.mem_valid_o, 0);
        tick();
        settle();
        chk("fetch gnt mem_valid", bus.mem_valid_o, 1);
        chk("fetch gnt mem_addr", bus.mem_addr_o, 32'h100);
        chk("fetch gnt instr_ready", bus.instr_ready_o, 0);
        tick();
        bus.mem_ready_i   = 1'b1;
        bus.mem_rdata_i   = 32'h0000_0013;
        bus.instr_valid_i = 1'b0;
        settle();
        chk("fetch done instr_ready", bus.instr_ready_o, 1);
        chk("fetch done instr_rdata", bus.instr_rdata_o, 32'h13);
        chk("fetch done mem_we", bus.mem_we_o, 0);
        chk("fetch done data_ready", bus.data_ready_o, 0);
        tick();
        bus.mem_ready_i = 1'b0;
        settle();
        chk("fetch after busy", busy, 0);
        tick();

        // ---------------- simultaneous requests ----------------
        clear_inputs();
        bus.instr_valid_i = 1'b1;
        bus.instr_addr_i  = 32'h0000_0300;
        bus.data_valid_i  = 1'b1;
        bus.data_addr_i   = 32'h0000_2000;
        bus.data_we_i     = 4'hF;
        bus.data_wdata_i  = 32'hDEAD_BEEF;
        settle();
        chk("simul idle busy", busy, 0);
        tick();
        bus.mem_ready_i = 1'b1;
        bus.data_valid_i = 1'b0;
        settle();
        chk("simul d addr", bus.mem_addr_o, 32'h2000);
        chk("simul d we", bus.mem_we_o, 4'hF);
        chk("simul d wdata", bus.mem_wdata_o, 32'hDEAD_BEEF);
        chk("simul d data_ready", bus.data_ready_o, 1);
        chk("simul d instr_ready", bus.instr_ready_o, 0);
        tick();
        bus.instr_valid_i = 1'b0;
        settle();
        chk("simul i mem_valid", bus.mem_valid_o, 1);
        chk("simul i addr", bus.mem_addr_o, 32'h300);
        chk("simul i we", bus.mem_we_o, 0);
        chk("simul i wdata", bus.mem_wdata_o, 0);
        chk("simul i instr_ready", bus.instr_ready_o, 1);
        tick();
        bus.mem_ready_i = 1'b0;
        settle();
        chk("simul end busy", busy, 0);
        tick();

        // ---------------- wait states ----------------
        clear_inputs();
        bus.data_valid_i = 1'b1;
        bus.data_addr_i  = 32'h0000_4000;
        bus.data_we_i    = 4'h3;
        bus.data_wdata_i = 32'hCAFE_F00D;
        settle();
        tick();
        for (int k = 0; k < 5; k++) begin
            settle();
            chk($sformatf("wait%0d addr", k), bus.mem_addr_o, 32'h4000);
            chk($sformatf("wait%0d we", k), bus.mem_we_o, 4'h3);
            chk($sformatf("wait%0d data_ready", k), bus.data_ready_o, 0);
            chk($sformatf("wait%0d mem_valid", k), bus.mem_valid_o, 1);
            tick();
        end
        bus.mem_ready_i  = 1'b1;
        bus.data_valid_i = 1'b0;
        settle();
        chk("wait done data_ready", bus.data_ready_o, 1);
        tick();
        bus.mem_ready_i = 1'b0;

        // ---------------- reset in the middle of a fetch ----------------
        clear_inputs();
        bus.instr_valid_i = 1'b1;
        bus.instr_addr_i  = 32'h0000_0500;
        settle();
        tick();
        settle();
        chk("rst mid busy before", busy, 1);
        #2;
        bus.mem_ready_i = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst mid mem_valid", bus.mem_valid_o, 0);
        chk("rst mid busy", busy, 0);
        chk("rst mid mem_addr", bus.mem_addr_o, 0);
        chk("rst mid instr_ready", bus.instr_ready_o, 0);
        bus.instr_valid_i = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("rst after%0d instr_ready", k), bus.instr_ready_o, 0);
            chk($sformatf("rst after%0d mem_valid", k), bus.mem_valid_o, 0);
            tick();
        end

        // ---------------- idle ----------------
        clear_inputs();
        for (int k = 0; k < 10; k++) begin
            bus.mem_ready_i = 1'($urandom_range(0, 1));
            settle();
            chk($sformatf("idle%0d mem_valid", k), bus.mem_valid_o, 0);
            chk($sformatf("idle%0d busy", k), busy, 0);
            tick();
        end

        // ---------------- randomized run vs reference model ----------------
        do_reset();
        m_gnt    = 0;
        m_streak = 0;
        for (int c = 0; c < 3000; c++) begin
            logic rdy;
            logic done_i;
            logic done_d;
            logic take;
            int   nxt;
            logic [31:0] e_addr;
            logic [31:0] e_wdata;
            logic [3:0]  e_we;

            rdy    = 1'($urandom_range(0, 1));
            done_i = (m_gnt == 1) && rdy;
            done_d = (m_gnt == 2) && rdy;

            // Requesters hold valid until served; on the serving cycle they
            // either drop valid or keep it up as a fresh request.
            if (!bus.instr_valid_i) begin
                if ($urandom_range(0, 2) == 0) begin
                    bus.instr_valid_i = 1'b1;
                    bus.instr_addr_i  = $urandom;
                end
            end else if (done_i) begin
                bus.instr_valid_i = ($urandom_range(0, 3) == 0);
            end
            if (!bus.data_valid_i) begin
                if ($urandom_range(0, 1) == 0) begin
                    bus.data_valid_i = 1'b1;
                    bus.data_addr_i  = $urandom;
                    bus.data_wdata_i = $urandom;
                    bus.data_we_i    = 4'($urandom_range(0, 15));
                end
            end else if (done_d) begin
                bus.data_valid_i = ($urandom_range(0, 2) != 0);
            end
            bus.mem_ready_i = rdy;
            bus.mem_rdata_i = $urandom;

            e_addr  = (m_gnt == 1) ? bus.instr_addr_i : (m_gnt == 2) ? bus.data_addr_i : 32'h0;
            e_wdata = (m_gnt == 2) ? bus.data_wdata_i : 32'h0;
            e_we    = (m_gnt == 2) ? bus.data_we_i : 4'h0;

            settle();
            chk($sformatf("rnd%0d mem_valid", c), bus.mem_valid_o, (m_gnt != 0));
            chk($sformatf("rnd%0d busy", c), busy, (m_gnt != 0));
            chk($sformatf("rnd%0d mem_addr", c), bus.mem_addr_o, e_addr);
            chk($sformatf("rnd%0d mem_wdata", c), bus.mem_wdata_o, e_wdata);
            chk($sformatf("rnd%0d mem_we", c), bus.mem_we_o, e_we);
            chk($sformatf("rnd%0d instr_ready", c), bus.instr_ready_o, done_i);
            chk($sformatf("rnd%0d data_ready", c), bus.data_ready_o, done_d);
            if (done_i) chk($sformatf("rnd%0d instr_rdata", c), bus.instr_rdata_o, bus.mem_rdata_i);
            if (done_d) chk($sformatf("rnd%0d data_rdata", c), bus.data_rdata_o, bus.mem_rdata_i);

            // Next grant: decided when idle or when the current one finishes.
            take = (m_gnt == 0) || rdy;
            nxt  = m_gnt;
            if (take) begin
                if (bus.data_valid_i && !(bus.instr_valid_i && m_streak >= MAX_STREAK))
                    nxt = 2;
                else if (bus.instr_valid_i)
                    nxt = 1;
                else
                    nxt = 0;
            end
            if (!bus.instr_valid_i)
                m_streak = 0;
            else if (take && nxt == 1)
                m_streak = 0;
            else if (take && nxt == 2 && m_streak < MAX_STREAK)
                m_streak = m_streak + 1;
            m_gnt = nxt;

            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
